// File: rtl/game_pkg.sv
// Shared memory-game definitions: checker FSM states, level lengths and the
// level-to-length mapping also used by the pattern generator.
package game_pkg;

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned LEN_W  = 5;
    localparam logic [LEN_W-1:0] LEN_L1 = 5'd8;
    localparam logic [LEN_W-1:0] LEN_L2 = 5'd12;
    localparam logic [LEN_W-1:0] LEN_L3 = 5'd16;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        COMPARE,
        REPORT
    } state_e;

    // Out-of-range levels clamp: 0 behaves as level 1, 4..7 as level 3.
    function automatic logic [LEN_W-1:0] level_to_len(input logic [2:0] level);
        logic [LEN_W-1:0] len;
        case (level)
            3'd0, 3'd1: len = LEN_L1;
            3'd2:       len = LEN_L2;
            default:    len = LEN_L3;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/seq_answer_checker_rise_detect.sv
// Registered rising-edge detector; the previous-value reset level is a parameter
// so a signal already high out of reset does not look like an edge.
module rise_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
        end else begin
            prev_q <= d;
            rise_q <= d & ~prev_q;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/seq_answer_checker.sv
// Compares the captured player sequence against the level's target pattern one
// slot per cycle and reports pass/fail, first mismatch slot and a saturating score.
module seq_answer_checker #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned IDX_W   = game_pkg::IDX_W,
    parameter int unsigned SCORE_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               level,
    input  logic                     end_signal,
    input  logic [MAX_LEN*IDX_W-1:0] user_seq,
    input  logic [MAX_LEN*IDX_W-1:0] target_seq,
    input  logic                     ack,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic [4:0]               mismatch_pos,
    output logic [SCORE_W-1:0]       score
);

    import game_pkg::*;

    localparam int unsigned PTR_W = $clog2(MAX_LEN);

    state_e             state_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic               fail_q;
    logic [4:0]         pos_q;
    logic [SCORE_W-1:0] score_q;
    logic [PTR_W-1:0]   idx_q;
    logic [LEN_W-1:0]   len_q;
    logic [IDX_W-1:0]   user_q   [MAX_LEN];
    logic [IDX_W-1:0]   target_q [MAX_LEN];
    logic               start;
    logic               slot_ne;
    logic               last_slot;

    // Resetting the previous value to 1 suppresses a start when end_signal is
    // already high as reset releases.
    rise_detect #(
        .RST_VAL(1'b1)
    ) u_end_rise (
        .clk (clk),
        .rst (rst),
        .d   (end_signal),
        .rise(start)
    );

    assign slot_ne   = user_q[idx_q] != target_q[idx_q];
    assign last_slot = LEN_W'(idx_q) == (len_q - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            pos_q   <= '0;
            score_q <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            for (int unsigned k = 0; k < MAX_LEN; k++) begin
                user_q[k]   <= '0;
                target_q[k] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LATCH;
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        fail_q  <= 1'b0;
                        pos_q   <= '0;
                        len_q   <= level_to_len(level);
                    end else if (ack) begin
                        pass_q <= 1'b0;
                        fail_q <= 1'b0;
                        pos_q  <= '0;
                    end
                end
                LATCH: begin
                    for (int unsigned k = 0; k < MAX_LEN; k++) begin
                        user_q[k]   <= user_seq[k*IDX_W +: IDX_W];
                        target_q[k] <= target_seq[k*IDX_W +: IDX_W];
                    end
                    idx_q   <= '0;
                    state_q <= COMPARE;
                end
                COMPARE: begin
                    if (slot_ne) begin
                        fail_q  <= 1'b1;
                        pos_q   <= 5'(idx_q);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= REPORT;
                    end else if (last_slot) begin
                        pass_q  <= 1'b1;
                        if (score_q != '1) begin
                            score_q <= score_q + SCORE_W'(1);
                        end
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= REPORT;
                    end else begin
                        idx_q <= idx_q + PTR_W'(1);
                    end
                end
                REPORT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign mismatch_pos = pos_q;
    assign score        = score_q;

endmodule
